poly_basemul_seq: RTL and testbench
===================================

// Module: poly_basemul_seq
// PURPOSE
//  Sequencer that computes one ML-KEM NTT-domain product (FIPS 203 MultiplyNTTs).
//  Reads 128 coefficient pairs from the A and B polynomial memories.
//  Streams each pair plus its gamma = 17^(2*BitRev7(i)+1) mod Q into an external base_case_mul.
//  Writes the returned (c0,c1) pairs in order to the C memory, then pulses done_o.
// PARAMETERS
//  N_PAIRS  128  coefficient pairs per polynomial (7-bit pair index)
//  RD_LAT   1    A/B memory read latency in cycles (rd_en_o to a*_i/b*_i valid)
// PORTS
//  clk          in   1         clock
//  rst          in   1         reset, asynchronous, active-low
//  start_i      in   1         start pulse; sampled only in IDLE
//  busy_o       out  1         high from the cycle after an accepted start until done_o (inclusive)
//  done_o       out  1         single-cycle completion pulse
//  err_o        out  1         sticky: result arrived with no operation outstanding
//  rd_en_o      out  1         A/B read strobe
//  rd_addr_o    out  7         pair index i (reads coeffs 2i, 2i+1 of A and B)
//  a0_i,a1_i    in   coeff_t   A pair from memory
//  b0_i,b1_i    in   coeff_t   B pair from memory
//  mul_valid_o  out  1         to base_case_mul valid_i
//  mul_a0_o..mul_b1_o  out coeff_t  registered operands to base_case_mul
//  mul_zeta_o   out  coeff_t   gamma for the pair, aligned with its operands
//  mul_valid_i  in   1         from base_case_mul valid_o
//  mul_c0_i,mul_c1_i   in coeff_t   results from base_case_mul
//  wr_en_o      out  1         C write strobe
//  wr_addr_o    out  7         pair index of the written result
//  wr_c0_o,wr_c1_o     out coeff_t  registered result pair
// BEHAVIOUR
//  Reset: FSM=IDLE; counters=0; every output=0.
//  FSM states:
//   IDLE: goes to RUN on start_i; clears err_o.
//   RUN: goes to DRAIN after rd_cnt==N_PAIRS-1 is issued.
//   DRAIN: goes to DONE when wr_cnt reaches N_PAIRS.
//   DONE: one cycle, done_o=1, then IDLE.
//  RUN: rd_en_o=1 every cycle; rd_addr_o=rd_cnt; rd_cnt increments 0..127.
//   Exactly 128 back-to-back reads, no bubbles.
//  Operand path: mul_valid_o and operands are registered.
//   Asserted exactly RD_LAT+1 cycles after the matching rd_en_o.
//   Result is 128 contiguous mul_valid_o cycles.
//  Gamma: taken from the ROM at index rd_addr and delayed to align with its operands.
//   gamma[2k+1] = Q - gamma[2k]; first entries 17, 3312, 2761, 568.
//  Result path: each cycle with mul_valid_i (while in RUN or DRAIN and outstanding>0):
//   next cycle wr_en_o=1, wr_addr_o=wr_cnt, wr_c0/c1_o = registered mul_c0/c1_i.
//   wr_cnt increments. Results are assumed in order; no reordering.
//  outstanding = issued - returned, 0..N_PAIRS.
//   mul_valid_i with outstanding==0, or in IDLE/DONE: dropped, no wr_en_o, err_o<=1.
//  done_o: the cycle after the 128th wr_en_o.
//   Independent of multiplier latency (completion is counted, not timed).
//  start_i while busy_o=1: ignored.
//   start_i coinciding with the done_o cycle: ignored; a new start is accepted only from IDLE.
//  rst asserted mid-operation: immediate return to IDLE, all outputs 0.
//   In-flight multiplier results after reset release are treated as spurious (err_o).
//  Counter wrap: rd_cnt/wr_cnt are 8-bit internally.
//   Terminal compare is at N_PAIRS; the 7-bit addresses never wrap within a run.
// STRUCTURE
//  poly_arith_pkg holds: coeff_t, Q=3329, N_PAIRS, and the 128-entry GAMMA constant array.
//  Sub-module basemul_gamma_rom: registered 7-bit index to coeff_t, 1-cycle latency.
//   Its latency is accounted for in the delay alignment.
//  base_case_mul is not instantiated here; the top level wires it between mul_* ports.
// TESTING (bench instantiates this block + base_case_mul + RD_LAT memory model)
//  1. Reset held, start_i=1 -> all outputs 0, no rd_en_o; after release start_i=0 -> stays IDLE.
//  2. A=B pairs (1,0) everywhere, start -> 128 wr_en_o, C[i]=(1,0) for all i, exactly one done_o, err_o=0.
//  3. A=B pairs (0,1) -> wr_c1_o=0 and wr_c0_o=gamma[i]: addr0=17, addr1=3312, addr2=2761, addr3=568; all 128 match GAMMA.
//  4. Random A,B -> C matches the golden base-case model.
//     First mul_valid_o exactly RD_LAT+1 cycles after first rd_en_o.
//     mul_valid_o contiguous 128 cycles; done_o exactly 1 cycle after last wr_en_o.
//  5. start_i pulsed at read 40 -> ignored, still 128 writes.
//     rst low at read 60 -> outputs 0 immediately; restart writes from addr 0.
//  6. mul_valid_i forced high in IDLE -> no wr_en_o, err_o=1 and holds; next start clears err_o.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared arithmetic definitions for the ML-KEM NTT-domain product path.
// Holds the coefficient type, the modulus, the pair count, the default
// A/B memory read latency, the sequencer state encoding and the 128-entry
// base-case twiddle table GAMMA[i] = 17^(2*BitRev7(i)+1) mod Q.
package poly_arith_pkg;

    localparam int unsigned Q          = 3329;
    localparam int unsigned N_PAIRS    = 128;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef logic [11:0] coeff_t;
    typedef logic [6:0]  pair_idx_t;
    // One bit wider than the pair index so the terminal count N_PAIRS is representable.
    typedef logic [7:0]  pair_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Odd entries are the negation of the preceding even entry: GAMMA[2k+1] = Q - GAMMA[2k].
    localparam coeff_t GAMMA [N_PAIRS] = '{
          17, 3312, 2761,  568,  583, 2746, 2649,  680,
        1637, 1692,  723, 2606, 2288, 1041, 1100, 2229,
        1409, 1920, 2662,  667, 3281,   48,  233, 3096,
         756, 2573, 2156, 1173, 3015,  314, 3050,  279,
        1703, 1626, 1651, 1678, 2789,  540, 1789, 1540,
        1847, 1482,  952, 2377, 1461, 1868, 2687,  642,
         939, 2390, 2308, 1021, 2437,  892, 2388,  941,
         733, 2596, 2337,  992,  268, 3061,  641, 2688,
        1584, 1745, 2298, 1031, 2037, 1292, 3220,  109,
         375, 2954, 2549,  780, 2090, 1239, 1645, 1684,
        1063, 2266,  319, 3010, 2773,  556,  757, 2572,
        2099, 1230,  561, 2768, 2466,  863, 2594,  735,
        2804,  525, 1092, 2237,  403, 2926, 1026, 2303,
        1143, 2186, 2150, 1179, 2775,  554,  886, 2443,
        1722, 1607, 1212, 2117, 1874, 1455, 1029, 2300,
        2110, 1219, 2935,  394,  885, 2444, 2154, 1175
    };

endpackage

// File: rtl/poly_basemul_seq_if.sv
// Bus bundle of the base-multiply sequencer: control/status, the A/B
// memory read port, the operand/result handshake with the external
// base_case_mul and the C memory write port.
// Modports: master = sequencer side, slave = environment side
// (memories, multiplier, controlling logic).
interface poly_basemul_seq_if;
    import poly_arith_pkg::*;

    logic      start_i;
    logic      busy_o;
    logic      done_o;
    logic      err_o;

    logic      rd_en_o;
    pair_idx_t rd_addr_o;
    coeff_t    a0_i, a1_i, b0_i, b1_i;

    logic      mul_valid_o;
    coeff_t    mul_a0_o, mul_a1_o, mul_b0_o, mul_b1_o, mul_zeta_o;
    logic      mul_valid_i;
    coeff_t    mul_c0_i, mul_c1_i;

    logic      wr_en_o;
    pair_idx_t wr_addr_o;
    coeff_t    wr_c0_o, wr_c1_o;

    modport master (
        input  start_i,
        output busy_o, done_o, err_o,
        output rd_en_o, rd_addr_o,
        input  a0_i, a1_i, b0_i, b1_i,
        output mul_valid_o, mul_a0_o, mul_a1_o, mul_b0_o, mul_b1_o, mul_zeta_o,
        input  mul_valid_i, mul_c0_i, mul_c1_i,
        output wr_en_o, wr_addr_o, wr_c0_o, wr_c1_o
    );

    modport slave (
        output start_i,
        input  busy_o, done_o, err_o,
        input  rd_en_o, rd_addr_o,
        output a0_i, a1_i, b0_i, b1_i,
        input  mul_valid_o, mul_a0_o, mul_a1_o, mul_b0_o, mul_b1_o, mul_zeta_o,
        output mul_valid_i, mul_c0_i, mul_c1_i,
        input  wr_en_o, wr_addr_o, wr_c0_o, wr_c1_o
    );

endinterface

// File: rtl/basemul_gamma_rom.sv
// Base-case twiddle ROM: registered lookup of GAMMA[idx_i], one cycle latency.
// Ports: clk, rst_n (async, active-low), idx_i (pair index), gamma_o (twiddle).
module basemul_gamma_rom
    import poly_arith_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  pair_idx_t idx_i,
    output coeff_t    gamma_o
);

    // NOTE: only the output register is reset; the table itself is a constant and needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gamma_o <= '0;
        else        gamma_o <= GAMMA[idx_i];
    end

endmodule

// File: rtl/poly_basemul_seq.sv
// Sequencer for one ML-KEM NTT-domain polynomial product. Reads the 128
// A/B coefficient pairs back-to-back, streams each pair with its gamma to
// an external base_case_mul, writes the returned pairs in order to C and
// pulses done_o once all 128 results have been written.
// Ports: clk, rst_n (async, active-low), bus (poly_basemul_seq_if.master):
//   start_i/busy_o/done_o/err_o   control and status
//   rd_en_o/rd_addr_o/a*_i/b*_i   A/B memory read port (RD_LAT cycles)
//   mul_*_o / mul_*_i             operand issue / result return
//   wr_en_o/wr_addr_o/wr_c*_o     C memory write port
// RD_LAT must be >= 1.
module poly_basemul_seq
    import poly_arith_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    poly_basemul_seq_if.master bus
);

    localparam pair_cnt_t LAST_IDX   = pair_cnt_t'(N_PAIRS - 1);
    localparam pair_cnt_t PAIR_TOTAL = pair_cnt_t'(N_PAIRS);

    seq_state_t        state_q, state_d;
    pair_cnt_t         rd_cnt, wr_cnt, iss_cnt;
    logic              rd_en, busy, done;
    pair_idx_t         rd_addr;
    logic [RD_LAT-1:0] rd_pipe;
    logic              rd_data_vld;
    pair_idx_t         rom_idx;
    coeff_t            rom_gamma;
    logic              start_ok, res_accept;

    assign start_ok = (state_q == ST_IDLE) && bus.start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en = 1'b1;
                if (rd_cnt == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_cnt == PAIR_TOTAL) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_addr       = rd_en ? rd_cnt[6:0] : '0;
    assign bus.rd_en_o   = rd_en;
    assign bus.rd_addr_o = rd_addr;
    assign bus.busy_o    = busy;
    assign bus.done_o    = done;

    // A result is only legal while a run is active and something is outstanding.
    assign res_accept = bus.mul_valid_i
                     && (state_q == ST_RUN || state_q == ST_DRAIN)
                     && (iss_cnt != wr_cnt);

    // iss_cnt advances on the same edge that raises mul_valid_o, so a
    // zero-latency multiplier already sees its operation as outstanding.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            iss_cnt <= '0;
        end else if (start_ok) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            iss_cnt <= '0;
        end else begin
            if (rd_en)       rd_cnt  <= rd_cnt + 1'b1;
            if (rd_data_vld) iss_cnt <= iss_cnt + 1'b1;
            if (res_accept)  wr_cnt  <= wr_cnt + 1'b1;
        end
    end

    // Read strobe delayed by the memory latency marks the cycle a*_i/b*_i are valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe <= '0;
        else        rd_pipe <= RD_LAT'({rd_pipe, rd_en});
    end
    assign rd_data_vld = rd_pipe[RD_LAT-1];

    // The ROM contributes one cycle, so its index is the read address delayed RD_LAT-1 cycles.
    if (RD_LAT == 1) begin : g_idx_now
        assign rom_idx = rd_addr;
    end else begin : g_idx_dly
        logic [RD_LAT-2:0][6:0] idx_sr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) idx_sr <= '0;
            else        idx_sr <= ((RD_LAT-1)*7)'({idx_sr, rd_addr});
        end
        assign rom_idx = idx_sr[RD_LAT-2];
    end

    basemul_gamma_rom u_gamma_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx_i   (rom_idx),
        .gamma_o (rom_gamma)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mul_valid_o <= 1'b0;
            bus.mul_a0_o    <= '0;
            bus.mul_a1_o    <= '0;
            bus.mul_b0_o    <= '0;
            bus.mul_b1_o    <= '0;
            bus.mul_zeta_o  <= '0;
        end else begin
            bus.mul_valid_o <= rd_data_vld;
            if (rd_data_vld) begin
                bus.mul_a0_o   <= bus.a0_i;
                bus.mul_a1_o   <= bus.a1_i;
                bus.mul_b0_o   <= bus.b0_i;
                bus.mul_b1_o   <= bus.b1_i;
                bus.mul_zeta_o <= rom_gamma;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en_o   <= 1'b0;
            bus.wr_addr_o <= '0;
            bus.wr_c0_o   <= '0;
            bus.wr_c1_o   <= '0;
        end else begin
            bus.wr_en_o <= res_accept;
            if (res_accept) begin
                bus.wr_addr_o <= wr_cnt[6:0];
                bus.wr_c0_o   <= bus.mul_c0_i;
                bus.wr_c1_o   <= bus.mul_c1_i;
            end
        end
    end

    // A spurious result is the stronger event, so it wins over the clear on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              bus.err_o <= 1'b0;
        else if (bus.mul_valid_i && !res_accept) bus.err_o <= 1'b1;
        else if (start_ok)                       bus.err_o <= 1'b0;
    end

endmodule

// File: tb/tb_poly_basemul_seq.sv
// Testbench for poly_basemul_seq: A/B memory model with one-cycle read
// latency, a behavioural base_case_mul with adjustable latency, and a
// reference product computed from FIPS 203 arithmetic with its own gamma
// table (17^(2*BitRev7(i)+1) mod Q).
module tb_poly_basemul_seq;
    import poly_arith_pkg::*;

    localparam int QI = 3329;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    poly_basemul_seq_if bus ();

    poly_basemul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int mem_a [256];
    int mem_b [256];
    int gamma_ref [128];

    // ---------------- reference arithmetic ----------------
    function automatic int bitrev7(input int x);
        int r = 0;
        for (int k = 0; k < 7; k++) if (x[k]) r = r | (1 << (6 - k));
        return r;
    endfunction

    function automatic int gamma_of(input int i);
        int     e = 2 * bitrev7(i) + 1;
        longint r = 1;
        for (int k = 0; k < e; k++) r = (r * 17) % QI;
        return int'(r);
    endfunction

    function automatic int bm_c0(input int a0, input int a1, input int b0, input int b1, input int g);
        longint t = (longint'(a1) * b1) % QI;
        return int'((longint'(a0) * b0 + t * g) % QI);
    endfunction

    function automatic int bm_c1(input int a0, input int a1, input int b0, input int b1);
        return int'((longint'(a0) * b1 + longint'(a1) * b0) % QI);
    endfunction

    // ---------------- A/B memory model (1-cycle read latency) ----------------
    always @(posedge clk) begin
        if (bus.rd_en_o === 1'b1) begin
            bus.a0_i <= coeff_t'(mem_a[2 * bus.rd_addr_o]);
            bus.a1_i <= coeff_t'(mem_a[2 * bus.rd_addr_o + 1]);
            bus.b0_i <= coeff_t'(mem_b[2 * bus.rd_addr_o]);
            bus.b1_i <= coeff_t'(mem_b[2 * bus.rd_addr_o + 1]);
        end
    end

    // ---------------- base_case_mul model, latency mul_lat (1..8) ----------------
    int mul_lat   = 3;
    bit force_mvi = 1'b0;
    bit pv  [8];
    int pc0 [8];
    int pc1 [8];

    always @(posedge clk) begin
        for (int k = 7; k > 0; k--) begin
            pv[k]  <= pv[k-1];
            pc0[k] <= pc0[k-1];
            pc1[k] <= pc1[k-1];
        end
        pv[0]  <= (bus.mul_valid_o === 1'b1);
        pc0[0] <= bm_c0(int'(bus.mul_a0_o), int'(bus.mul_a1_o), int'(bus.mul_b0_o),
                        int'(bus.mul_b1_o), int'(bus.mul_zeta_o));
        pc1[0] <= bm_c1(int'(bus.mul_a0_o), int'(bus.mul_a1_o), int'(bus.mul_b0_o),
                        int'(bus.mul_b1_o));
    end

    assign bus.mul_valid_i = pv[mul_lat-1] | force_mvi;
    assign bus.mul_c0_i    = coeff_t'(pc0[mul_lat-1]);
    assign bus.mul_c1_i    = coeff_t'(pc1[mul_lat-1]);

    // ---------------- monitor (samples on the falling edge) ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_count, mv_count, mv_runs, wr_count, done_count;
    int first_rd_cyc, first_mv_cyc, last_wr_cyc, done_cyc;
    int rd_order_err, wr_order_err;
    bit mv_prev;
    int c0_got [128];
    int c1_got [128];

    always @(negedge clk) begin
        if (bus.rd_en_o === 1'b1) begin
            if (bus.rd_addr_o !== 7'(rd_count)) rd_order_err++;
            if (rd_count == 0) first_rd_cyc = cyc;
            rd_count++;
        end
        if (bus.mul_valid_o === 1'b1) begin
            if (mv_count == 0) first_mv_cyc = cyc;
            if (!mv_prev) mv_runs++;
            mv_count++;
        end
        mv_prev = (bus.mul_valid_o === 1'b1);
        if (bus.wr_en_o === 1'b1) begin
            if (bus.wr_addr_o !== 7'(wr_count)) wr_order_err++;
            c0_got[bus.wr_addr_o] = int'(bus.wr_c0_o);
            c1_got[bus.wr_addr_o] = int'(bus.wr_c1_o);
            wr_count++;
            last_wr_cyc = cyc;
        end
        if (bus.done_o === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Settles #1 past the falling edge so monitor updates are visible.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_count = 0; mv_count = 0; mv_runs = 0; wr_count = 0; done_count = 0;
        first_rd_cyc = -1; first_mv_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        rd_order_err = 0; wr_order_err = 0; mv_prev = 1'b0;
        for (int i = 0; i < 128; i++) begin
            c0_got[i] = -1;
            c1_got[i] = -1;
        end
    endtask

    task automatic fill_const(input int p0, input int p1);
        for (int i = 0; i < 128; i++) begin
            mem_a[2*i] = p0; mem_a[2*i+1] = p1;
            mem_b[2*i] = p0; mem_b[2*i+1] = p1;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = int'($urandom_range(QI - 1, 0));
            mem_b[i] = int'($urandom_range(QI - 1, 0));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s_busy", tag),     bus.busy_o, 0);
        check($sformatf("%s_done", tag),     bus.done_o, 0);
        check($sformatf("%s_rd_en", tag),    bus.rd_en_o, 0);
        check($sformatf("%s_rd_addr", tag),  bus.rd_addr_o, 0);
        check($sformatf("%s_mul_vld", tag),  bus.mul_valid_o, 0);
        check($sformatf("%s_mul_zeta", tag), bus.mul_zeta_o, 0);
        check($sformatf("%s_mul_a0", tag),   bus.mul_a0_o, 0);
        check($sformatf("%s_wr_en", tag),    bus.wr_en_o, 0);
        check($sformatf("%s_wr_c0", tag),    bus.wr_c0_o, 0);
    endtask

    // One full product; optional ignored start during RUN and on the done_o cycle.
    task automatic run_op(input string tag, input int restart_at, input bit start_on_done);
        int budget;
        bit pulsed;
        clear_stats();
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        check($sformatf("%s_busy_after_start", tag), bus.busy_o, 1);
        check($sformatf("%s_err_cleared", tag), bus.err_o, 0);
        budget = 0;
        pulsed = 1'b0;
        while (done_count == 0 && budget < 2000) begin
            if (restart_at >= 0 && !pulsed && rd_count >= restart_at) begin
                bus.start_i = 1'b1;
                pulsed      = 1'b1;
                tick(1);
                bus.start_i = 1'b0;
            end else begin
                tick(1);
            end
            budget++;
        end
        check($sformatf("%s_done_seen", tag), done_count, 1);
        if (start_on_done && done_count == 1) begin
            bus.start_i = 1'b1;
            tick(1);
            bus.start_i = 1'b0;
            check($sformatf("%s_start_on_done_ignored", tag), bus.busy_o, 0);
        end
        tick(10);
        check($sformatf("%s_rd_count", tag),   rd_count, 128);
        check($sformatf("%s_rd_order", tag),   rd_order_err, 0);
        check($sformatf("%s_mv_count", tag),   mv_count, 128);
        check($sformatf("%s_mv_contig", tag),  mv_runs, 1);
        check($sformatf("%s_mv_latency", tag), first_mv_cyc - first_rd_cyc, RD_LAT_DEF + 1);
        check($sformatf("%s_wr_count", tag),   wr_count, 128);
        check($sformatf("%s_wr_order", tag),   wr_order_err, 0);
        check($sformatf("%s_done_count", tag), done_count, 1);
        check($sformatf("%s_done_timing", tag), done_cyc - last_wr_cyc, 1);
        check($sformatf("%s_err", tag),        bus.err_o, 0);
        check($sformatf("%s_idle_busy", tag),  bus.busy_o, 0);
        for (int i = 0; i < 128; i++) begin
            check($sformatf("%s_c0[%0d]", tag, i), c0_got[i],
                  bm_c0(mem_a[2*i], mem_a[2*i+1], mem_b[2*i], mem_b[2*i+1], gamma_ref[i]));
            check($sformatf("%s_c1[%0d]", tag, i), c1_got[i],
                  bm_c1(mem_a[2*i], mem_a[2*i+1], mem_b[2*i], mem_b[2*i+1]));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int budget;
        for (int i = 0; i < 128; i++) gamma_ref[i] = gamma_of(i);
        clear_stats();
        force_mvi   = 1'b0;
        bus.start_i = 1'b1;
        rst_n       = 1'b0;

        // 1. reset held with start_i high, then release with start_i low
        tick(4);
        check_outputs_zero("rst_held");
        check("rst_held_err", bus.err_o, 0);
        check("rst_held_no_reads", rd_count, 0);
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
        tick(6);
        check("post_rst_idle_busy", bus.busy_o, 0);
        check("post_rst_no_reads", rd_count, 0);

        // 2. A=B pairs (1,0): every product pair is (1,0)
        mul_lat = 3;
        fill_const(1, 0);
        run_op("ones", -1, 1'b0);

        // 3. A=B pairs (0,1): c0 is gamma[i], c1 is 0
        mul_lat = 1;
        fill_const(0, 1);
        run_op("gamma", -1, 1'b0);
        check("gamma_addr0", c0_got[0], 17);
        check("gamma_addr1", c0_got[1], 3312);
        check("gamma_addr2", c0_got[2], 2761);
        check("gamma_addr3", c0_got[3], 568);

        // 4. random operands; a start on the done_o cycle must be ignored
        mul_lat = 4;
        fill_rand();
        run_op("rand", -1, 1'b1);

        // 5a. start pulsed during read 40 is ignored
        mul_lat = 2;
        fill_rand();
        run_op("restart40", 40, 1'b0);

        // 5b. reset mid-run at read 60, then a clean restart
        mul_lat = 5;
        fill_rand();
        clear_stats();
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        budget = 0;
        while (rd_count < 60 && budget < 500) begin
            tick(1);
            budget++;
        end
        check("rst60_reached", rd_count, 60);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst60");
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("rst60_spurious_err", bus.err_o, 1);
        check("rst60_idle", bus.busy_o, 0);
        fill_rand();
        run_op("after_rst", -1, 1'b0);

        // 6. result with nothing outstanding in IDLE
        tick(10);
        clear_stats();
        force_mvi = 1'b1;
        tick(3);
        force_mvi = 1'b0;
        tick(1);
        check("idle_mvi_no_write", wr_count, 0);
        check("idle_mvi_err", bus.err_o, 1);
        tick(5);
        check("idle_mvi_err_holds", bus.err_o, 1);
        mul_lat = 3;
        fill_rand();
        run_op("err_clear", -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
